// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display stage: font constants, display
// modes and the hex-to-segment lookup. Segment vectors are {g,f,e,d,c,b,a}, active-high.
package seg_display_pkg;

  typedef enum logic [0:0] {
    MODE_TOP  = 1'b0,
    MODE_SIZE = 1'b1
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b1101101;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_if.sv
// Connection between the calculator core and the display stage: stack status in,
// multiplexed segment/anode drive out.
interface seg_display_if;

  logic [15:0] in_top;
  logic        in_hi;
  logic [6:0]  in_stack_size;
  logic        in_empty;
  logic        in_error;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (
    output in_top, in_hi, in_stack_size, in_empty, in_error,
    input  seg, dp, an
  );

  modport slave (
    input  in_top, in_hi, in_stack_size, in_empty, in_error,
    output seg, dp, an
  );

endinterface

// File: rtl/seg_display_bin2bcd7.sv
// Combinational double-dabble: 7-bit binary (0..127) to three BCD digits.
module bin2bcd7 (
  input  logic [6:0] i_bin,
  output logic [3:0] o_hund,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  // Shift register layout: [18:15] hundreds, [14:11] tens, [10:7] ones, [6:0] binary.
  logic [18:0] w_sh;

  always_comb begin
    w_sh      = '0;
    w_sh[6:0] = i_bin;
    for (int i = 0; i < 7; i++) begin
      if (w_sh[10:7]  >= 4'd5) w_sh[10:7]  = w_sh[10:7]  + 4'd3;
      if (w_sh[14:11] >= 4'd5) w_sh[14:11] = w_sh[14:11] + 4'd3;
      if (w_sh[18:15] >= 4'd5) w_sh[18:15] = w_sh[18:15] + 4'd3;
      w_sh = {w_sh[17:0], 1'b0};
    end
  end

  assign o_hund = w_sh[18:15];
  assign o_tens = w_sh[14:11];
  assign o_ones = w_sh[10:7];

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment display for the RPN calculator core: shows the
// top of stack, a timed stack-size view after each depth change, and blinks on error.
module seg_display
  import seg_display_pkg::*;
#(
  parameter int DIGIT_CYCLES     = 50000,
  parameter int BLINK_CYCLES     = 25000000,
  parameter int SIZE_SHOW_CYCLES = 100000000,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input logic          clk,
  input logic          rst,
  seg_display_if.slave disp
);

  localparam int SLOT_W  = $clog2(DIGIT_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam int TMR_W   = $clog2(SIZE_SHOW_CYCLES);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(SIZE_SHOW_CYCLES - 1);

  // Inactive levels; XOR-ing an active-high value with these gives the pin polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [SLOT_W-1:0]  r_slot;
  logic [1:0]         r_idx;
  mode_e              r_mode;
  logic               r_phase;
  logic [BLINK_W-1:0] r_blink;
  logic [TMR_W-1:0]   r_tmr;

  logic [15:0] r_top;
  logic [6:0]  r_size;
  logic        r_empty;
  logic        r_err;
  logic        r_hi;

  logic [6:0] r_seg;
  logic       r_dp;
  logic [3:0] r_an;

  logic       w_slot_last;
  logic       w_wrap;
  logic       w_size_chg;
  logic       w_err_next;
  logic       w_tmr_done;
  logic [3:0] w_hund;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  logic       w_dp;
  logic [3:0] w_an;

  assign w_slot_last = (r_slot == SLOT_LAST);
  assign w_wrap      = w_slot_last && (r_idx == 2'd3);
  assign w_size_chg  = w_wrap && (disp.in_stack_size != r_size);
  assign w_err_next  = w_wrap ? disp.in_error : r_err;
  assign w_tmr_done  = (r_tmr == TMR_LAST);

  bin2bcd7 u_bcd (
    .i_bin  (r_size),
    .o_hund (w_hund),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  always_comb begin
    case (r_idx)
      2'd0:    w_nib = r_top[3:0];
      2'd1:    w_nib = r_top[7:4];
      2'd2:    w_nib = r_top[11:8];
      default: w_nib = r_top[15:12];
    endcase
  end

  always_comb begin
    w_seg = SEG_BLANK;
    w_dp  = 1'b0;
    if (r_mode == MODE_SIZE) begin
      case (r_idx)
        2'd3:    w_seg = SEG_S;
        2'd2:    w_seg = (w_hund != 4'd0) ? hex_to_seg(w_hund) : SEG_BLANK;
        2'd1:    w_seg = (w_hund != 4'd0 || w_tens != 4'd0) ? hex_to_seg(w_tens) : SEG_BLANK;
        default: w_seg = hex_to_seg(w_ones);
      endcase
    end else begin
      w_seg = r_empty ? SEG_DASH : hex_to_seg(w_nib);
      w_dp  = r_hi && (r_idx == 2'd3);
    end
    // The error marker on digit 0 is deliberately immune to the blink phase.
    if (r_err && r_idx == 2'd0) w_dp = 1'b1;
    if (!r_phase) w_seg = SEG_BLANK;
  end

  assign w_an = (r_slot == '0) ? 4'b0000 : 4'(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= '0;
      r_idx   <= '0;
      r_mode  <= MODE_TOP;
      r_phase <= 1'b1;
      r_blink <= '0;
      r_tmr   <= '0;
      r_top   <= '0;
      r_size  <= '0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
      r_hi    <= 1'b0;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_an    <= AN_OFF;
    end else begin
      r_slot <= w_slot_last ? '0 : r_slot + SLOT_W'(1);
      if (w_slot_last) r_idx <= r_idx + 2'd1;

      // Inputs are sampled only between full scans so a frame never mixes two values.
      if (w_wrap) begin
        r_top   <= disp.in_top;
        r_hi    <= disp.in_hi;
        r_size  <= disp.in_stack_size;
        r_empty <= disp.in_empty;
        r_err   <= disp.in_error;
      end

      case (r_mode)
        MODE_TOP: begin
          if (w_size_chg) begin
            r_mode <= MODE_SIZE;
            r_tmr  <= '0;
          end
        end
        MODE_SIZE: begin
          if (w_size_chg) begin
            r_tmr <= '0;
          end else if (w_wrap && w_tmr_done) begin
            r_mode <= MODE_TOP;
            r_tmr  <= '0;
          end else if (!w_tmr_done) begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        default: r_mode <= MODE_TOP;
      endcase

      // Phase is forced on the moment a clean snapshot is taken, not one cycle later.
      if (!w_err_next) begin
        r_blink <= '0;
        r_phase <= 1'b1;
      end else if (r_err) begin
        if (r_blink == BLINK_LAST) begin
          r_blink <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_blink <= r_blink + BLINK_W'(1);
        end
      end

      r_seg <= w_seg ^ SEG_OFF;
      r_dp  <= w_dp ^ DP_OFF;
      r_an  <= w_an ^ AN_OFF;
    end
  end

  assign disp.seg = r_seg;
  assign disp.dp  = r_dp;
  assign disp.an  = r_an;

endmodule

// File: tb/tb_seg_display.sv
// Scoreboard bench for seg_display: each scan's expected digits are queued when the
// stimulus is applied and compared digit by digit as the multiplexer visits them.
module tb_seg_display;

  typedef struct packed {
    logic [27:0] segs;
    logic [3:0]  dps;
  } scan_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_chk  = 0;
  int    n_pass = 0;
  scan_t exp_q[$];

  seg_display_if disp ();

  seg_display #(
    .DIGIT_CYCLES     (4),
    .BLINK_CYCLES     (64),
    .SIZE_SHOW_CYCLES (128),
    .ACTIVE_LOW       (1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'b0111111;  4'h1: f = 7'b0000110;  4'h2: f = 7'b1011011;
      4'h3: f = 7'b1001111;  4'h4: f = 7'b1100110;  4'h5: f = 7'b1101101;
      4'h6: f = 7'b1111101;  4'h7: f = 7'b0000111;  4'h8: f = 7'b1111111;
      4'h9: f = 7'b1101111;  4'hA: f = 7'b1110111;  4'hB: f = 7'b1111100;
      4'hC: f = 7'b0111001;  4'hD: f = 7'b1011110;  4'hE: f = 7'b1111001;
      default: f = 7'b1110001;
    endcase
    return f;
  endfunction

  function automatic scan_t top_view(input logic [15:0] top, input logic hi,
                                     input logic empty, input logic err, input logic lit);
    scan_t      s;
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      nib = top[4*k +: 4];
      s.segs[7*k +: 7] = !lit ? 7'b0000000 : (empty ? 7'b1000000 : font(nib));
    end
    s.dps = {hi, 2'b00, err};
    return s;
  endfunction

  function automatic scan_t size_view(input int n, input logic err);
    scan_t s;
    int    h, t, o;
    h = n / 100;
    t = (n / 10) % 10;
    o = n % 10;
    s.segs[27:21] = 7'b1101101;
    s.segs[20:14] = (h != 0) ? font(4'(h)) : 7'b0000000;
    s.segs[13:7]  = (h != 0 || t != 0) ? font(4'(t)) : 7'b0000000;
    s.segs[6:0]   = font(4'(o));
    s.dps = {3'b000, err};
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %0b, expected %0b", tag, got, want);
    else n_pass++;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] tgt, inout logic [3:0] prev);
    bit found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clk);
      if (disp.an == tgt) found = 1'b1;
      else prev = disp.an;
    end
    if (!found) check_eq({tag, " an timeout"}, 32'(disp.an), 32'(tgt));
  endtask

  // Observes one full scan (digits 0..3); optionally changes in_top while digit 1 is lit.
  task automatic run_scan(input string tag, input bit mid_en, input logic [15:0] mid_top);
    scan_t      want;
    logic [3:0] prev;
    check_eq({tag, " queue depth"}, 32'(exp_q.size()), 32'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    prev = disp.an;
    for (int k = 0; k < 4; k++) begin
      wait_an(tag, 4'(1 << k), prev);
      check_eq($sformatf("%s blank%0d", tag, k), 32'(prev), 32'd0);
      check_eq($sformatf("%s seg%0d", tag, k), 32'(disp.seg), 32'(want.segs[7*k +: 7]));
      check_eq($sformatf("%s dp%0d", tag, k), 32'(disp.dp), 32'(want.dps[k]));
      if (mid_en && k == 1) disp.in_top = mid_top;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst                = 1'b1;
    disp.in_top        = 16'h0000;
    disp.in_hi         = 1'b0;
    disp.in_stack_size = 7'd0;
    disp.in_empty      = 1'b1;
    disp.in_error      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst an", 32'(disp.an), 32'd0);
    check_eq("rst seg", 32'(disp.seg), 32'd0);
    check_eq("rst dp", 32'(disp.dp), 32'd0);
    rst = 1'b0;

    exp_q.push_back(top_view(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
    run_scan("dash", 1'b0, 16'h0);

    disp.in_empty = 1'b0;
    disp.in_top   = 16'h1A2F;
    disp.in_hi    = 1'b1;
    exp_q.push_back(top_view(16'h1A2F, 1'b1, 1'b0, 1'b0, 1'b1));
    run_scan("top", 1'b0, 16'h0);

    disp.in_stack_size = 7'd3;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(size_view(3, 1'b0));
      run_scan($sformatf("size3_%0d", j), 1'b0, 16'h0);
    end
    exp_q.push_back(top_view(16'h1A2F, 1'b1, 1'b0, 1'b0, 1'b1));
    run_scan("size3_back", 1'b0, 16'h0);

    disp.in_stack_size = 7'd10;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(size_view(10, 1'b0));
      run_scan($sformatf("size10_%0d", j), 1'b0, 16'h0);
    end
    disp.in_stack_size = 7'd105;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(size_view(105, 1'b0));
      run_scan($sformatf("size105_%0d", j), 1'b0, 16'h0);
    end
    exp_q.push_back(top_view(16'h1A2F, 1'b1, 1'b0, 1'b0, 1'b1));
    run_scan("size105_back", 1'b0, 16'h0);

    disp.in_error = 1'b1;
    disp.in_hi    = 1'b0;
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(top_view(16'h1A2F, 1'b0, 1'b0, 1'b1, (j < 4)));
      run_scan($sformatf("blink_%0d", j), 1'b0, 16'h0);
    end
    disp.in_error = 1'b0;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(top_view(16'h1A2F, 1'b0, 1'b0, 1'b0, 1'b1));
      run_scan($sformatf("err_clr_%0d", j), 1'b0, 16'h0);
    end

    exp_q.push_back(top_view(16'h1A2F, 1'b0, 1'b0, 1'b0, 1'b1));
    run_scan("tear_old", 1'b1, 16'hBEEF);
    exp_q.push_back(top_view(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1));
    run_scan("tear_new", 1'b0, 16'h0);

    disp.in_stack_size = 7'd20;
    exp_q.push_back(size_view(20, 1'b0));
    run_scan("size20", 1'b0, 16'h0);
    rst                = 1'b1;
    disp.in_stack_size = 7'd0;
    @(negedge clk);
    check_eq("midrst an", 32'(disp.an), 32'd0);
    check_eq("midrst seg", 32'(disp.seg), 32'd0);
    check_eq("midrst dp", 32'(disp.dp), 32'd0);
    rst = 1'b0;
    exp_q.push_back(top_view(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
    run_scan("post_rst", 1'b0, 16'h0);
    exp_q.push_back(top_view(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1));
    run_scan("post_rst_top", 1'b0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
